dm_ctrl: RTL and testbench

Data-memory access controller sitting directly downstream of the data address generator. Takes the DM address produced by the DAG (`dg_dm_add`) and a request from the program sequencer, then performs a single-word read or write on an internal data-memory array. Each access takes a programmable number of wait states. It returns read data to the bus-connect path and drives busy/ack back to the sequencer for stalling.

---
 rtl/dm_ctrl.sv | 117 +++++++++++
 tb/tb_dm_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: single-word data-memory access controller with programmable wait states.
// Optional out-of-range address checking is enabled by defining DM_ADDR_CHK_EN.
module dm_ctrl #(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps_dm_en,
  input  logic        ps_dm_wrt_en,
  input  logic [15:0] dg_dm_add,
  input  logic [15:0] bc_dt,
  output logic [15:0] dm_bc_dt,
  output logic        dm_ps_busy,
  output logic        dm_ps_ack,
  output logic        dm_ps_err
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] LOAD_CNT = 3'(WAIT_CYC);

  // state  | meaning
  // S_IDLE | ready; a request latches addr/data/dir and loads the wait counter
  // S_WAIT | access in flight; counter runs down, array accessed when it hits zero
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_done;
  logic        w_oor;
  logic [AW-1:0] w_idx;

  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_wrt;
  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic [15:0] r_mem [DEPTH];

  assign w_idx = r_addr[AW-1:0];

`ifdef DM_ADDR_CHK_EN
  assign w_oor = ({16'd0, r_addr} >= 32'(DEPTH));
`else
  // Upper address bits simply wrap; they are latched but never consulted.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = |(r_addr >> AW);
  assign w_oor            = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ps_dm_en) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LOAD_CNT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 3'd0) begin
          w_cnt_nxt = r_cnt - 3'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
      r_wrt   <= 1'b0;
      r_rdata <= 16'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_done;
      r_err   <= w_done & w_oor;
      if (w_accept) begin
        r_addr  <= dg_dm_add;
        r_wdata <= bc_dt;
        r_wrt   <= ps_dm_wrt_en;
      end
      if (w_done && !r_wrt) begin
        r_rdata <= w_oor ? 16'd0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset; an aborted access never reaches w_done, so no write occurs.
  always_ff @(posedge clk) begin
    if (w_done && r_wrt && !w_oor) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign dm_bc_dt   = r_rdata;
  assign dm_ps_busy = (r_state == S_WAIT);
  assign dm_ps_ack  = r_ack;
  assign dm_ps_err  = r_err;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed steps plus randomized accesses against a memory model.
// Expectations follow DM_ADDR_CHK_EN when it is defined for the build.
module tb_dm_ctrl;
  localparam int W = 2;

`ifdef DM_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, wrt, busy, ack, err;
  logic [15:0] add, wdt, rdt;
  logic        en0, wrt0, busy0, ack0, err0;
  logic [15:0] add0, wdt0, rdt0;

  dm_ctrl #(.DEPTH(256), .WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n), .ps_dm_en(en), .ps_dm_wrt_en(wrt),
    .dg_dm_add(add), .bc_dt(wdt), .dm_bc_dt(rdt),
    .dm_ps_busy(busy), .dm_ps_ack(ack), .dm_ps_err(err));

  dm_ctrl #(.DEPTH(256), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ps_dm_en(en0), .ps_dm_wrt_en(wrt0),
    .dg_dm_add(add0), .bc_dt(wdt0), .dm_bc_dt(rdt0),
    .dm_ps_busy(busy0), .dm_ps_ack(ack0), .dm_ps_err(err0));

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mdl_mem  [256];
  logic [15:0] mdl0_mem [256];
  logic [15:0] mdl_dt;
  logic [15:0] mdl0_dt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; the request is taken at the next edge.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input bit pulse);
    int lat;
    int bcnt;
    bit got;
    bit oor;
    oor = CHK && (a >= 16'd256);
    en = 1'b1; wrt = w; add = a; wdt = d;
    @(posedge clk); #1;
    en = 1'b0; wrt = 1'($urandom); add = 16'($urandom); wdt = 16'($urandom);
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 20) begin
      if (busy) bcnt++;
      en = pulse && (lat == 1);
      @(posedge clk); #1;
      lat++;
      got = ack;
    end
    en = 1'b0;
    if (w) begin
      if (!oor) mdl_mem[a[7:0]] = d;
    end else begin
      mdl_dt = oor ? 16'h0000 : mdl_mem[a[7:0]];
    end
    chk("ack_latency", lat, W + 1);
    chk("busy_cycles", bcnt, W + 1);
    chk("busy_at_ack", busy, 1'b0);
    chk("err_at_ack", err, oor);
    chk("rdata", rdt, mdl_dt);
  endtask

  task automatic access0(input logic w, input logic [15:0] a, input logic [15:0] d);
    int lat;
    bit got;
    en0 = 1'b1; wrt0 = w; add0 = a; wdt0 = d;
    @(posedge clk); #1;
    en0 = 1'b0;
    chk("w0_busy_after_accept", busy0, 1'b1);
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      got = ack0;
    end
    if (w) mdl0_mem[a[7:0]] = d;
    else   mdl0_dt = mdl0_mem[a[7:0]];
    chk("w0_ack_latency", lat, 1);
    chk("w0_busy_at_ack", busy0, 1'b0);
    chk("w0_rdata", rdt0, mdl0_dt);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; wrt = 1'b0; add = 16'h0; wdt = 16'h0;
    en0 = 1'b0; wrt0 = 1'b0; add0 = 16'h0; wdt0 = 16'h0;
    mdl_dt = 16'h0; mdl0_dt = 16'h0;
    #2;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ack", ack, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rdata", rdt, 16'h0000);
    chk("reset_w0_busy", busy0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 16'h0010, 16'h1234, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("raw_0010", rdt, 16'h1234);

    for (int i = 0; i < 256; i++) access(1'b1, 16'(i), 16'($urandom), 1'b0);

    // Back-to-back read on the write's ack cycle, with a stray request while busy.
    access(1'b1, 16'h00FF, 16'hBEEF, 1'b0);
    access(1'b0, 16'h00FF, 16'h0000, 1'b1);
    chk("b2b_beef", rdt, 16'hBEEF);
    @(posedge clk); #1;
    chk("no_extra_ack", ack, 1'b0);
    chk("no_extra_busy", busy, 1'b0);

    access(1'b1, 16'h0005, 16'hA5A5, 1'b0);
    access(1'b1, 16'h0105, 16'h5555, 1'b0);
    access(1'b0, 16'h0005, 16'h0000, 1'b0);
    chk("loc5_after_0105", rdt, CHK ? 16'hA5A5 : 16'h5555);
    access(1'b0, 16'h0105, 16'h0000, 1'b0);

    // Reset during the wait of a write must leave the location untouched.
    access(1'b1, 16'h0020, 16'h1357, 1'b0);
    access(1'b0, 16'h0020, 16'h0000, 1'b0);
    en = 1'b1; wrt = 1'b1; add = 16'h0020; wdt = 16'h7777;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    mdl_dt = 16'h0000; mdl0_dt = 16'h0000;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ack", ack, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    chk("rst_mid_rdata", rdt, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 16'h0020, 16'h0000, 1'b0);
    chk("abort_kept_0020", rdt, 16'h1357);

    for (int i = 0; i < 200; i++) begin
      int gap;
      access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), 16'($urandom),
             1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("idle_no_ack", ack, 1'b0);
      end
    end

    access0(1'b1, 16'h0003, 16'h0A0A);
    access0(1'b0, 16'h0003, 16'h0000);
    chk("w0_read_0a0a", rdt0, 16'h0A0A);
    access0(1'b1, 16'h0004, 16'h0B0B);
    access0(1'b0, 16'h0004, 16'h0000);
    access0(1'b0, 16'h0003, 16'h0000);
    chk("w0_err_quiet", err0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
